nn_spike_scheduler: RTL

- Sits between the wishbone_nn register block and the analog neuron/synapse array.
- Buffers neuron/synapse IDs written by the host in a small FIFO.
- Replays each ID onto the array's synapse-address bus with guaranteed hold and gap timing, so the analog array sees clean, stable address pulses instead of raw register-write timing.
- Returns status (busy, level, event count) for host readback.

---
 rtl/nn_pkg.sv | 24 ++
 rtl/nn_id_fifo.sv | 54 +++++
 rtl/nn_spike_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the neuron/synapse scheduling path.
// Also consumed by the wishbone_nn status decoder.
`ifndef NN_ID_BUS
`define NN_ID_BUS 8
`endif

package nn_pkg;

   localparam int unsigned NN_ID_W         = `NN_ID_BUS;
   localparam int unsigned NN_IDLE_ID      = 0;
   localparam int unsigned NN_HOLD_DEFAULT = 4;
   localparam int unsigned NN_GAP_DEFAULT  = 2;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDrive = 2'd1,
      StGap   = 2'd2
   } nn_state_e;

   function automatic int unsigned nn_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nn_id_fifo.sv
// Synchronous ID FIFO with extra-MSB pointers, level output and synchronous clear.
// Push into a full FIFO and pop from an empty one are ignored.
module nn_id_fifo
   import nn_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned ID_W  = NN_ID_W
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_clr,
   input  logic                     i_push,
   input  logic [ID_W-1:0]          i_id,
   input  logic                     i_pop,
   output logic [ID_W-1:0]          o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [ID_W-1:0] r_mem [DEPTH];
   logic [AW:0]     r_wptr;
   logic [AW:0]     r_rptr;
   logic            w_do_push;
   logic            w_do_pop;

   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_empty   = (r_wptr == r_rptr);
   assign o_level   = r_wptr - r_rptr;
   assign o_head    = r_mem[r_rptr[AW-1:0]];
   assign w_do_push = i_push && !o_full && !i_clr;
   assign w_do_pop  = i_pop && !o_empty && !i_clr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_clr) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: entries are only read between valid pointers.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_id;
   end

endmodule

// File: rtl/nn_spike_scheduler.sv
// Replays buffered neuron/synapse IDs onto the analog array address bus with fixed
// hold and gap timing; reports busy, FIFO level and an event count for host readback.
module nn_spike_scheduler
   import nn_pkg::*;
#(
   parameter int unsigned     ID_W        = NN_ID_W,
   parameter int unsigned     DEPTH       = 8,
   parameter int unsigned     HOLD_CYCLES = NN_HOLD_DEFAULT,
   parameter int unsigned     GAP_CYCLES  = NN_GAP_DEFAULT,
   parameter logic [ID_W-1:0] IDLE_ID     = ID_W'(NN_IDLE_ID),
   parameter int unsigned     CNT_W       = 16
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_ni,
   input  logic                    enable,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ID_W-1:0]         in_id,
   output logic [ID_W-1:0]         syn_addr,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic [CNT_W-1:0]        evt_count
);

   localparam int unsigned CW = $clog2(nn_max(HOLD_CYCLES, GAP_CYCLES)) + 1;
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

   nn_state_e        r_state;
   logic [CW-1:0]    r_cnt;
   logic [ID_W-1:0]  r_syn_addr;
   logic [CNT_W-1:0] r_evt_count;

   logic             w_full;
   logic             w_empty;
   logic [ID_W-1:0]  w_head;
   logic             w_push;
   logic             w_pop;
   logic             w_can_start;

   // Gated by reset so the upstream block never sees a handshake during reset.
   assign in_ready    = wb_rst_ni && !w_full && !flush;
   // IDLE_ID completes the handshake but is dropped here, never stored.
   assign w_push      = in_valid && in_ready && (in_id != IDLE_ID);
   assign w_can_start = enable && !w_empty && !flush;
   assign w_pop       = w_can_start &&
                        ((r_state == StIdle) || ((r_state == StGap) && (r_cnt == '0)));

   nn_id_fifo #(
      .DEPTH (DEPTH),
      .ID_W  (ID_W)
   ) u_fifo (
      .i_clk   (wb_clk_i),
      .i_rst_n (wb_rst_ni),
      .i_clr   (flush),
      .i_push  (w_push),
      .i_id    (in_id),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_syn_addr  <= IDLE_ID;
         r_evt_count <= '0;
      end else if (flush) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_syn_addr <= IDLE_ID;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_pop) begin
                  r_syn_addr  <= w_head;
                  r_cnt       <= HOLD_LOAD;
                  r_evt_count <= r_evt_count + CNT_W'(1);
                  r_state     <= StDrive;
               end else begin
                  r_syn_addr <= IDLE_ID;
               end
            end
            StDrive: begin
               if (r_cnt == '0) begin
                  r_syn_addr <= IDLE_ID;
                  r_cnt      <= GAP_LOAD;
                  r_state    <= StGap;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            StGap: begin
               if (r_cnt == '0) begin
                  // Back-to-back issue skips IDLE to keep the period at HOLD+GAP.
                  if (w_pop) begin
                     r_syn_addr  <= w_head;
                     r_cnt       <= HOLD_LOAD;
                     r_evt_count <= r_evt_count + CNT_W'(1);
                     r_state     <= StDrive;
                  end else begin
                     r_state <= StIdle;
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_state    <= StIdle;
               r_syn_addr <= IDLE_ID;
            end
         endcase
      end
   end

   assign syn_addr  = r_syn_addr;
   assign evt_count = r_evt_count;
   assign busy      = (r_state != StIdle) || !w_empty;

endmodule
